ex_mem_reg: RTL and testbench

- EX/MEM pipeline register directly downstream of the execute-stage arithmetic, logic and shift units (including the 16-bit arithmetic right shifter).
- Captures the EX result and its control bundle, and supplies them to the memory stage.
- Owns the architectural flag register (Z, V, N), updated per opcode class.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/ex_mem_reg_pkg.sv | 43 ++++
 rtl/ex_mem_reg_if.sv | 43 ++++
 rtl/ex_mem_reg_flag_unit.sv | 38 +++
 rtl/ex_mem_reg.sv | 74 +++++++
 tb/tb_ex_mem_reg.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register: widths, opcodes, flag
// bit positions and the registered stage bundle.
package ex_mem_reg_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD    = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB    = 4'd1;
    localparam logic [OP_W-1:0] OP_XOR    = 4'd2;
    localparam logic [OP_W-1:0] OP_RED    = 4'd3;
    localparam logic [OP_W-1:0] OP_SLL    = 4'd4;
    localparam logic [OP_W-1:0] OP_SRA    = 4'd5;
    localparam logic [OP_W-1:0] OP_ROR    = 4'd6;
    localparam logic [OP_W-1:0] OP_PADDSB = 4'd7;
    localparam logic [OP_W-1:0] OP_LW     = 4'd8;
    localparam logic [OP_W-1:0] OP_SW     = 4'd9;
    localparam logic [OP_W-1:0] OP_LHB    = 4'd10;
    localparam logic [OP_W-1:0] OP_LLB    = 4'd11;
    localparam logic [OP_W-1:0] OP_B      = 4'd12;
    localparam logic [OP_W-1:0] OP_BR     = 4'd13;
    localparam logic [OP_W-1:0] OP_PCS    = 4'd14;
    localparam logic [OP_W-1:0] OP_HLT    = 4'd15;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] rd;
        logic              wr_en;
        logic              mem_rd;
        logic              mem_wr;
        logic [DATA_W-1:0] store_data;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX/MEM boundary bundle: EX-side inputs, hazard controls, MEM-side outputs and flags.
// The slave modport is the pipeline register; the master side is the surrounding pipeline.
interface ex_mem_reg_if;
    import ex_mem_reg_pkg::*;

    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic [OP_W-1:0]   ex_opcode;
    logic [DATA_W-1:0] ex_result;
    logic              ex_ovfl;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wr_en;
    logic              ex_mem_rd;
    logic              ex_mem_wr;
    logic [DATA_W-1:0] ex_store_data;

    logic              mem_valid;
    logic [OP_W-1:0]   mem_opcode;
    logic [DATA_W-1:0] mem_result;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_wr_en;
    logic              mem_mem_rd;
    logic              mem_mem_wr;
    logic [DATA_W-1:0] mem_store_data;
    logic [2:0]        flags;
    logic [2:0]        flags_next;

    modport master (
        output stall, flush, ex_valid, ex_opcode, ex_result, ex_ovfl, ex_rd,
               ex_wr_en, ex_mem_rd, ex_mem_wr, ex_store_data,
        input  mem_valid, mem_opcode, mem_result, mem_rd, mem_wr_en,
               mem_mem_rd, mem_mem_wr, mem_store_data, flags, flags_next
    );

    modport slave (
        input  stall, flush, ex_valid, ex_opcode, ex_result, ex_ovfl, ex_rd,
               ex_wr_en, ex_mem_rd, ex_mem_wr, ex_store_data,
        output mem_valid, mem_opcode, mem_result, mem_rd, mem_wr_en,
               mem_mem_rd, mem_mem_wr, mem_store_data, flags, flags_next
    );

endinterface

// File: rtl/ex_mem_reg_flag_unit.sv
// Combinational next-flag logic: opcode class decode, zero detect and sign bit.
// With i_update low the current flags pass through unchanged.
module ex_mem_reg_flag_unit
    import ex_mem_reg_pkg::*;
(
    input  logic              i_update,
    input  logic [OP_W-1:0]   i_opcode,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_ovfl,
    input  logic [2:0]        i_flags,
    output logic [2:0]        o_flags_next
);

    logic w_zero;

    assign w_zero = (i_result == '0);

    always_comb begin
        o_flags_next = i_flags;
        if (i_update) begin
            case (i_opcode)
                OP_ADD, OP_SUB: begin
                    o_flags_next[FLAG_Z] = w_zero;
                    o_flags_next[FLAG_V] = i_ovfl;
                    o_flags_next[FLAG_N] = i_result[DATA_W-1];
                end
                // Logic and shift ops only define Z; V and N keep their last arithmetic value.
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    o_flags_next[FLAG_Z] = w_zero;
                end
                default: begin
                    o_flags_next = i_flags;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush and the architectural {Z,V,N} flag register.
// Define EX_MEM_FLAG_FWD_EN to make flags_next a same-cycle bypass of the next flag value.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    ex_mem_reg_if.slave  bus
);

    stage_t     w_stage_in;
    stage_t     r_stage;
    logic [2:0] r_flags;
    logic [2:0] w_flags_calc;
    logic       w_load;
    logic       w_flag_upd;

    assign w_load     = !bus.flush && !bus.stall;
    assign w_flag_upd = w_load && bus.ex_valid;

    // Enables are qualified by ex_valid so a bubble can never write anything.
    always_comb begin
        w_stage_in            = STAGE_BUBBLE;
        w_stage_in.valid      = bus.ex_valid;
        w_stage_in.opcode     = bus.ex_opcode;
        w_stage_in.result     = bus.ex_result;
        w_stage_in.rd         = bus.ex_rd;
        w_stage_in.wr_en      = bus.ex_valid && bus.ex_wr_en;
        w_stage_in.mem_rd     = bus.ex_valid && bus.ex_mem_rd;
        w_stage_in.mem_wr     = bus.ex_valid && bus.ex_mem_wr;
        w_stage_in.store_data = bus.ex_store_data;
    end

    ex_mem_reg_flag_unit u_flag_unit (
        .i_update     (w_flag_upd),
        .i_opcode     (bus.ex_opcode),
        .i_result     (bus.ex_result),
        .i_ovfl       (bus.ex_ovfl),
        .i_flags      (r_flags),
        .o_flags_next (w_flags_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= STAGE_BUBBLE;
            r_flags <= 3'b000;
        end else begin
            if (bus.flush) begin
                r_stage <= STAGE_BUBBLE;
            end else if (!bus.stall) begin
                r_stage <= w_stage_in;
            end
            // w_flags_calc already folds in stall, flush and valid as a hold.
            r_flags <= w_flags_calc;
        end
    end

    assign bus.mem_valid      = r_stage.valid;
    assign bus.mem_opcode     = r_stage.opcode;
    assign bus.mem_result     = r_stage.result;
    assign bus.mem_rd         = r_stage.rd;
    assign bus.mem_wr_en      = r_stage.wr_en;
    assign bus.mem_mem_rd     = r_stage.mem_rd;
    assign bus.mem_mem_wr     = r_stage.mem_wr;
    assign bus.mem_store_data = r_stage.store_data;
    assign bus.flags          = r_flags;

`ifdef EX_MEM_FLAG_FWD_EN
    assign bus.flags_next = w_flags_calc;
`else
    assign bus.flags_next = r_flags;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vector table, reset corner sequences,
// then randomized cycles against a behavioural model of the pipeline register.
module tb_ex_mem_reg;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    ex_mem_reg_if bus ();

    ex_mem_reg u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic        fl;
        logic        v;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ov;
        logic        wr;
        logic        mr;
        logic        mw;
        logic [15:0] exp_res;
        logic [3:0]  exp_ctl;   // {valid, wr_en, mem_rd, mem_wr}
        logic [2:0]  exp_flags; // {Z, V, N}
    } vec_t;

    vec_t vecs[18];

    // Reference model state: what the MEM-side registers should hold.
    logic        m_valid;
    logic [3:0]  m_op;
    logic [15:0] m_res;
    logic [3:0]  m_rd;
    logic        m_wr;
    logic        m_mr;
    logic        m_mw;
    logic [15:0] m_sd;
    logic [2:0]  m_flags;

    function automatic vec_t mk(input string name, input logic st, input logic fl,
                                input logic v, input logic [3:0] op, input logic [15:0] res,
                                input logic ov, input logic wr, input logic mr, input logic mw,
                                input logic [15:0] exp_res, input logic [3:0] exp_ctl,
                                input logic [2:0] exp_flags);
        vec_t t;
        t.name = name; t.st = st; t.fl = fl; t.v = v; t.op = op; t.res = res; t.ov = ov;
        t.wr = wr; t.mr = mr; t.mw = mw;
        t.exp_res = exp_res; t.exp_ctl = exp_ctl; t.exp_flags = exp_flags;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [43:0] dut_stage();
        return {bus.mem_valid, bus.mem_opcode, bus.mem_result, bus.mem_rd,
                bus.mem_wr_en, bus.mem_mem_rd, bus.mem_mem_wr, bus.mem_store_data};
    endfunction

    function automatic logic [43:0] model_stage();
        return {m_valid, m_op, m_res, m_rd, m_wr, m_mr, m_mw, m_sd};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = 0; m_res = 0; m_rd = 0;
        m_wr = 0; m_mr = 0; m_mw = 0; m_sd = 0; m_flags = 0;
    endtask

    function automatic logic [2:0] model_flags(input logic st, input logic fl, input logic v,
                                               input logic [3:0] op, input logic [15:0] res,
                                               input logic ov, input logic [2:0] cur);
        logic [2:0] f;
        f = cur;
        if (!fl && !st && v) begin
            if (op == 4'd0 || op == 4'd1)
                f = {res == 16'd0, ov, res[15]};
            else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6)
                f[2] = (res == 16'd0);
        end
        return f;
    endfunction

    task automatic drive(input logic st, input logic fl, input logic v, input logic [3:0] op,
                         input logic [15:0] res, input logic ov, input logic [3:0] rd,
                         input logic wr, input logic mr, input logic mw, input logic [15:0] sd);
        bus.stall = st; bus.flush = fl; bus.ex_valid = v; bus.ex_opcode = op;
        bus.ex_result = res; bus.ex_ovfl = ov; bus.ex_rd = rd; bus.ex_wr_en = wr;
        bus.ex_mem_rd = mr; bus.ex_mem_wr = mw; bus.ex_store_data = sd;
    endtask

    // Called just after a falling edge: drive, check bypass, clock, compare with the model.
    task automatic apply_model(input string name, input logic st, input logic fl, input logic v,
                               input logic [3:0] op, input logic [15:0] res, input logic ov,
                               input logic [3:0] rd, input logic wr, input logic mr,
                               input logic mw, input logic [15:0] sd);
        logic [2:0] nf;
        drive(st, fl, v, op, res, ov, rd, wr, mr, mw, sd);
        nf = model_flags(st, fl, v, op, res, ov, m_flags);
        #1;
`ifdef EX_MEM_FLAG_FWD_EN
        check({name, "_flags_next"}, {61'd0, bus.flags_next}, {61'd0, nf});
`else
        check({name, "_flags_next"}, {61'd0, bus.flags_next}, {61'd0, m_flags});
`endif
        if (fl) begin
            m_valid = 0; m_op = 0; m_res = 0; m_rd = 0; m_wr = 0; m_mr = 0; m_mw = 0; m_sd = 0;
        end else if (!st) begin
            m_valid = v; m_op = op; m_res = res; m_rd = rd;
            m_wr = v & wr; m_mr = v & mr; m_mw = v & mw; m_sd = sd;
        end
        m_flags = nf;
        @(posedge clk);
        #1;
        check({name, "_stage"}, {20'd0, dut_stage()}, {20'd0, model_stage()});
        check({name, "_flags"}, {61'd0, bus.flags}, {61'd0, m_flags});
        $display("%s: st=%0b fl=%0b v=%0b op=%0d res=%h -> mem_res=%h flags=%b",
                 name, st, fl, v, op, res, bus.mem_result, bus.flags);
    endtask

    initial begin
        logic [2:0] cur_flags;
        n_checks = 0;
        n_errors = 0;
        model_reset();

        //        name           st fl v  op     res       ov wr mr mw  exp_res   ctl      flags
        vecs[0]  = mk("add_8000",   0, 0, 1, 4'd0,  16'h8000, 1, 1, 0, 0, 16'h8000, 4'b1100, 3'b011);
        vecs[1]  = mk("sra_zero",   0, 0, 1, 4'd5,  16'h0000, 0, 1, 0, 0, 16'h0000, 4'b1100, 3'b111);
        vecs[2]  = mk("sub_0005",   0, 0, 1, 4'd1,  16'h0005, 0, 1, 0, 0, 16'h0005, 4'b1100, 3'b000);
        vecs[3]  = mk("stall_1",    1, 0, 1, 4'd1,  16'hFFFF, 1, 1, 0, 0, 16'h0005, 4'b1100, 3'b000);
        vecs[4]  = mk("stall_2",    1, 0, 1, 4'd1,  16'hFFFF, 1, 1, 0, 0, 16'h0005, 4'b1100, 3'b000);
        vecs[5]  = mk("stall_3",    1, 0, 1, 4'd1,  16'hFFFF, 1, 1, 0, 0, 16'h0005, 4'b1100, 3'b000);
        vecs[6]  = mk("xor_zero",   0, 0, 1, 4'd2,  16'h0000, 1, 1, 0, 0, 16'h0000, 4'b1100, 3'b100);
        vecs[7]  = mk("sll_nz",     0, 0, 1, 4'd4,  16'h0040, 1, 1, 0, 0, 16'h0040, 4'b1100, 3'b000);
        vecs[8]  = mk("add_neg",    0, 0, 1, 4'd0,  16'hF000, 0, 1, 0, 0, 16'hF000, 4'b1100, 3'b001);
        vecs[9]  = mk("ror_zero",   0, 0, 1, 4'd6,  16'h0000, 1, 1, 0, 0, 16'h0000, 4'b1100, 3'b101);
        vecs[10] = mk("flush_stall",1, 1, 1, 4'd0,  16'h1234, 1, 1, 0, 1, 16'h0000, 4'b0000, 3'b101);
        vecs[11] = mk("invalid_add",0, 0, 0, 4'd0,  16'h0000, 0, 1, 1, 1, 16'h0000, 4'b0000, 3'b101);
        vecs[12] = mk("lw_hold",    0, 0, 1, 4'd8,  16'h0000, 1, 1, 1, 0, 16'h0000, 4'b1110, 3'b101);
        vecs[13] = mk("sw_store",   0, 0, 1, 4'd9,  16'h0000, 0, 0, 0, 1, 16'h0000, 4'b1001, 3'b101);
        vecs[14] = mk("paddsb",     0, 0, 1, 4'd7,  16'h0000, 1, 1, 0, 0, 16'h0000, 4'b1100, 3'b101);
        vecs[15] = mk("flush_only", 0, 1, 1, 4'd1,  16'h0007, 0, 1, 0, 0, 16'h0000, 4'b0000, 3'b101);
        vecs[16] = mk("red_zero",   0, 0, 1, 4'd3,  16'h0000, 1, 1, 0, 0, 16'h0000, 4'b1100, 3'b101);
        vecs[17] = mk("sub_ovfl",   0, 0, 1, 4'd1,  16'h7FFF, 1, 1, 0, 0, 16'h7FFF, 4'b1100, 3'b010);

        // Reset held for two cycles: every output must read zero.
        rst_n = 1'b0;
        drive(0, 0, 0, 4'd0, 16'd0, 0, 4'd0, 0, 0, 0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_stage", {20'd0, dut_stage()}, 64'd0);
        check("reset_flags", {61'd0, bus.flags}, 64'd0);
        check("reset_flags_next", {61'd0, bus.flags_next}, 64'd0);
        $display("reset: mem_res=%h flags=%b", bus.mem_result, bus.flags);
        @(negedge clk);
        rst_n = 1'b1;

        cur_flags = 3'b000;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].st, vecs[i].fl, vecs[i].v, vecs[i].op, vecs[i].res, vecs[i].ov,
                  4'd3, vecs[i].wr, vecs[i].mr, vecs[i].mw, 16'h00AA);
            #1;
`ifdef EX_MEM_FLAG_FWD_EN
            check({vecs[i].name, "_flags_next"}, {61'd0, bus.flags_next}, {61'd0, vecs[i].exp_flags});
`else
            check({vecs[i].name, "_flags_next"}, {61'd0, bus.flags_next}, {61'd0, cur_flags});
`endif
            @(posedge clk);
            #1;
            check({vecs[i].name, "_result"}, {48'd0, bus.mem_result}, {48'd0, vecs[i].exp_res});
            check({vecs[i].name, "_ctl"},
                  {60'd0, bus.mem_valid, bus.mem_wr_en, bus.mem_mem_rd, bus.mem_mem_wr},
                  {60'd0, vecs[i].exp_ctl});
            check({vecs[i].name, "_flags"}, {61'd0, bus.flags}, {61'd0, vecs[i].exp_flags});
            $display("%s: mem_res=%h ctl=%b flags=%b", vecs[i].name, bus.mem_result,
                     {bus.mem_valid, bus.mem_wr_en, bus.mem_mem_rd, bus.mem_mem_wr}, bus.flags);
            cur_flags = vecs[i].exp_flags;
        end

        // Reset asserted mid-stall clears at once; the first edge after release loads normally.
        @(negedge clk);
        drive(1, 0, 1, 4'd0, 16'h5555, 1, 4'd9, 1, 0, 0, 16'h1111);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall_stage", {20'd0, dut_stage()}, 64'd0);
        check("rst_mid_stall_flags", {61'd0, bus.flags}, 64'd0);
        $display("rst_mid_stall: mem_res=%h flags=%b", bus.mem_result, bus.flags);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply_model("rst_first_load", 0, 0, 1, 4'd0, 16'h0000, 0, 4'd5, 1, 0, 0, 16'h2222);
        check("rst_first_load_zflag", {61'd0, bus.flags}, {61'd0, 3'b100});

        // Reset asserted mid-flush clears immediately as well.
        @(negedge clk);
        drive(0, 1, 1, 4'd1, 16'h8001, 1, 4'd2, 1, 1, 1, 16'h3333);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_flush_stage", {20'd0, dut_stage()}, 64'd0);
        check("rst_mid_flush_flags", {61'd0, bus.flags}, 64'd0);
        $display("rst_mid_flush: mem_res=%h flags=%b", bus.mem_result, bus.flags);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            logic        st, fl, v, ov, wr, mr, mw;
            logic [3:0]  op, rd;
            logic [15:0] res, sd;
            st  = ($urandom_range(0, 9) < 2);
            fl  = ($urandom_range(0, 9) < 1);
            v   = ($urandom_range(0, 19) < 17);
            op  = 4'($urandom_range(0, 15));
            res = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            ov  = 1'($urandom);
            rd  = 4'($urandom);
            wr  = 1'($urandom);
            mr  = 1'($urandom);
            mw  = 1'($urandom);
            sd  = 16'($urandom);
            if (i > 0) @(negedge clk);
            apply_model($sformatf("rnd%0d", i), st, fl, v, op, res, ov, rd, wr, mr, mw, sd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
